// File: rtl/video_text_ram_if.sv
// Bus bundle for video_text_ram: CPU random-access port, display read port
// and the clear-engine handshake. The master side is the CPU decode / video
// timing logic; the slave side is the RAM itself.
interface video_text_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  // CPU port
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we_n;
  logic              cpu_re_n;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  // Display (scan-out) port
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_re;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  // Clear engine control
  logic              clear_req;
  logic              busy;
  logic              clear_done;

  // Requester side: drives addresses, strobes and the clear request
  modport master (
    output cpu_addr, cpu_wdata, cpu_we_n, cpu_re_n,
    output disp_addr, disp_re,
    output clear_req,
    input  cpu_rdata, cpu_rvalid,
    input  disp_rdata, disp_rvalid,
    input  busy, clear_done
  );

  // RAM side: consumes requests, returns registered read data and status
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we_n, cpu_re_n,
    input  disp_addr, disp_re,
    input  clear_req,
    output cpu_rdata, cpu_rvalid,
    output disp_rdata, disp_rvalid,
    output busy, clear_done
  );
endinterface

// File: rtl/video_text_ram.sv
// Single-clock text/video RAM. The CPU port does random reads and writes,
// the display port is read-only for the character generator, and a clear
// engine fills the whole array with a blank code. The array has a single
// write port: the CPU owns it in IDLE and the clear engine owns it in CLEAR.
// Display reads are write-first against whichever writer is active.
module video_text_ram #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 11,
  parameter int                DEPTH     = 2048,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h20
) (
  input logic             clk,
  input logic             reset_n,
  video_text_ram_if.slave bus
);

  // Word count and last index carried one bit wider than the address so
  // that DEPTH == 2**ADDR_W is representable and the pointer never wraps early.
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] L_LAST  = L_DEPTH - L_ONE;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Storage: contents are deliberately never reset
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Control state
  state_t            r_state;
  logic [ADDR_W:0]   r_ptr;
  logic              r_busy;
  logic              r_clearDone;

  // Registered read ports
  logic [DATA_W-1:0] r_cpuRdata;
  logic              r_cpuRvalid;
  logic [DATA_W-1:0] r_dispRdata;
  logic              r_dispRvalid;

  // Decoded request and shared write-port signals
  logic              w_cpuInRange;
  logic              w_dispInRange;
  logic              w_cpuWrite;
  logic              w_cpuRead;
  logic              w_clrWrite;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memData;
  logic [ADDR_W-1:0] w_ptrIdx;
  logic              w_dispHit;

  // Addresses at or beyond DEPTH are outside the array
  assign w_cpuInRange  = ({1'b0, bus.cpu_addr}  < L_DEPTH);
  assign w_dispInRange = ({1'b0, bus.disp_addr} < L_DEPTH);

  // The pointer only ever holds 0..DEPTH-1, so its low bits index the array
  assign w_ptrIdx = r_ptr[ADDR_W-1:0];

  // CPU strobes are honoured only in IDLE; a write beats a simultaneous read.
  // Nothing is written on a reset edge, so a reset mid-clear stops cleanly.
  assign w_cpuWrite = reset_n && (r_state == ST_IDLE) && !bus.cpu_we_n;
  assign w_cpuRead  = reset_n && (r_state == ST_IDLE) &&  bus.cpu_we_n && !bus.cpu_re_n;
  assign w_clrWrite = reset_n && (r_state == ST_CLEAR);

  // Single write port: the clear engine and the CPU are never active together
  assign w_memWe   = w_clrWrite || (w_cpuWrite && w_cpuInRange);
  assign w_memAddr = w_clrWrite ? w_ptrIdx  : bus.cpu_addr;
  assign w_memData = w_clrWrite ? CLEAR_VAL : bus.cpu_wdata;

  // Display read collides with the word being written this cycle
  assign w_dispHit = w_memWe && (w_memAddr == bus.disp_addr);

  // Control FSM: IDLE serves the CPU, CLEAR walks the pointer over every word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_clearDone <= 1'b0;
    end else begin
      r_clearDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.clear_req) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_ptr == L_LAST) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_clearDone <= 1'b1;
          end
          r_ptr <= r_ptr + L_ONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write from whichever agent currently owns the write port
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  // CPU read port: one-cycle latency, data held until the next CPU read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cpuRdata  <= '0;
      r_cpuRvalid <= 1'b0;
    end else begin
      r_cpuRvalid <= w_cpuRead;
      if (w_cpuRead) begin
        if (w_cpuInRange) begin
          r_cpuRdata <= r_mem[bus.cpu_addr];
        end else begin
          r_cpuRdata <= '0;
        end
      end
    end
  end

  // Display read port: served in every state, write-first on a collision
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dispRdata  <= '0;
      r_dispRvalid <= 1'b0;
    end else begin
      r_dispRvalid <= bus.disp_re;
      if (bus.disp_re) begin
        if (!w_dispInRange) begin
          r_dispRdata <= '0;
        end else if (w_dispHit) begin
          r_dispRdata <= w_memData;
        end else begin
          r_dispRdata <= r_mem[bus.disp_addr];
        end
      end
    end
  end

  assign bus.cpu_rdata   = r_cpuRdata;
  assign bus.cpu_rvalid  = r_cpuRvalid;
  assign bus.disp_rdata  = r_dispRdata;
  assign bus.disp_rvalid = r_dispRvalid;
  assign bus.busy        = r_busy;
  assign bus.clear_done  = r_clearDone;

endmodule

// File: tb/tb_video_text_ram.sv
// Testbench for video_text_ram. Two instances: a full 2048-word array and a
// 1000-word array in a 10-bit address space for the out-of-range cases.
// The 2048-word instance is tracked by a plain array model of its contents.
module tb_video_text_ram;

  localparam int DW     = 8;
  localparam int AWA    = 11;
  localparam int DEPTHA = 2048;
  localparam int AWB    = 10;
  localparam int DEPTHB = 1000;

  logic clk = 1'b0;
  logic reset_n;

  int testCount = 0;
  int failCount = 0;

  // Reference contents and expected held read data for instance A
  logic [7:0] modelA [DEPTHA];
  logic [7:0] expCpuA;
  logic [7:0] expDispA;

  video_text_ram_if #(.DATA_W(DW), .ADDR_W(AWA)) busA ();
  video_text_ram_if #(.DATA_W(DW), .ADDR_W(AWB)) busB ();

  video_text_ram #(
    .DATA_W(DW), .ADDR_W(AWA), .DEPTH(DEPTHA), .CLEAR_VAL(8'h20)
  ) dutA (
    .clk(clk), .reset_n(reset_n), .bus(busA)
  );

  video_text_ram #(
    .DATA_W(DW), .ADDR_W(AWB), .DEPTH(DEPTHB), .CLEAR_VAL(8'h20)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .bus(busB)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleA();
    busA.cpu_we_n  = 1'b1;
    busA.cpu_re_n  = 1'b1;
    busA.cpu_addr  = '0;
    busA.cpu_wdata = '0;
    busA.disp_re   = 1'b0;
    busA.disp_addr = '0;
    busA.clear_req = 1'b0;
  endtask

  task automatic idleB();
    busB.cpu_we_n  = 1'b1;
    busB.cpu_re_n  = 1'b1;
    busB.cpu_addr  = '0;
    busB.cpu_wdata = '0;
    busB.disp_re   = 1'b0;
    busB.disp_addr = '0;
    busB.clear_req = 1'b0;
  endtask

  // One idle-state cycle on instance A, predicted from the content model
  task automatic applyStimulus(input logic weN, input logic reN, input logic dispRe,
                               input logic [10:0] cAddr, input logic [10:0] dAddr,
                               input logic [7:0] wData);
    logic expCpuValid;
    busA.cpu_we_n  = weN;
    busA.cpu_re_n  = reN;
    busA.cpu_addr  = cAddr;
    busA.cpu_wdata = wData;
    busA.disp_re   = dispRe;
    busA.disp_addr = dAddr;
    expCpuValid = weN && !reN;
    if (expCpuValid) expCpuA = modelA[cAddr];
    if (dispRe) expDispA = (!weN && (cAddr == dAddr)) ? wData : modelA[dAddr];
    if (!weN) modelA[cAddr] = wData;
    tick();
    checkOutput("A cpu_rvalid",  busA.cpu_rvalid,  expCpuValid);
    checkOutput("A cpu_rdata",   busA.cpu_rdata,   expCpuA);
    checkOutput("A disp_rvalid", busA.disp_rvalid, dispRe);
    checkOutput("A disp_rdata",  busA.disp_rdata,  expDispA);
    checkOutput("A busy idle",   busA.busy,        1'b0);
    idleA();
  endtask

  // One cycle on instance B; checks are made by the caller
  task automatic driveB(input logic weN, input logic reN, input logic dispRe,
                        input logic [9:0] cAddr, input logic [9:0] dAddr,
                        input logic [7:0] wData);
    busB.cpu_we_n  = weN;
    busB.cpu_re_n  = reN;
    busB.cpu_addr  = cAddr;
    busB.cpu_wdata = wData;
    busB.disp_re   = dispRe;
    busB.disp_addr = dAddr;
    tick();
    idleB();
  endtask

  initial begin
    int busyCycles;
    int doneWhileBusy;
    logic weN, reN, dispRe;
    logic [10:0] cAddr, dAddr;
    logic [7:0] wData;

    // ---- Reset held for two clocks ----
    idleA();
    idleB();
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("A rst cpu_rdata",   busA.cpu_rdata,   8'h00);
    checkOutput("A rst cpu_rvalid",  busA.cpu_rvalid,  1'b0);
    checkOutput("A rst disp_rdata",  busA.disp_rdata,  8'h00);
    checkOutput("A rst disp_rvalid", busA.disp_rvalid, 1'b0);
    checkOutput("A rst busy",        busA.busy,        1'b0);
    checkOutput("A rst clear_done",  busA.clear_done,  1'b0);
    checkOutput("B rst cpu_rdata",   busB.cpu_rdata,   8'h00);
    checkOutput("B rst busy",        busB.busy,        1'b0);
    reset_n  = 1'b1;
    expCpuA  = 8'h00;
    expDispA = 8'h00;

    // ---- CPU write then read back ----
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h005, 11'h000, 8'h41);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h005, 11'h000, 8'h00);
    checkOutput("A read 0x005 data", busA.cpu_rdata, 8'h41);
    applyStimulus(1'b1, 1'b1, 1'b0, 11'h000, 11'h000, 8'h00);
    checkOutput("A rvalid one cycle", busA.cpu_rvalid, 1'b0);

    // ---- Write-first collision on the display port ----
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h010, 11'h010, 8'h7E);
    checkOutput("A disp write-first", busA.disp_rdata, 8'h7E);

    // ---- Both strobes low: write wins, no read ----
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h020, 11'h000, 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h020, 11'h000, 8'h00);

    // ---- Full clear with CPU traffic and a collision mid-clear ----
    busA.clear_req = 1'b1;
    tick();
    busA.clear_req = 1'b0;
    busyCycles    = 0;
    doneWhileBusy = 0;
    while (busA.busy === 1'b1 && busyCycles < 3000) begin
      busyCycles++;
      busA.disp_re   = (busyCycles == 17);
      busA.disp_addr = 11'h010;
      busA.cpu_we_n  = !(busyCycles == 500);
      busA.cpu_addr  = 11'h123;
      busA.cpu_wdata = 8'h55;
      busA.cpu_re_n  = !(busyCycles == 600);
      busA.clear_req = (busyCycles == 700);
      tick();
      if (busA.busy === 1'b1 && busA.clear_done === 1'b1) doneWhileBusy++;
      if (busyCycles == 17) begin
        checkOutput("A disp vs clear write", busA.disp_rdata, 8'h20);
        checkOutput("A disp valid in clear", busA.disp_rvalid, 1'b1);
      end
      if (busyCycles == 600) begin
        checkOutput("A cpu read ignored", busA.cpu_rvalid, 1'b0);
        checkOutput("A cpu rdata held",   busA.cpu_rdata,  expCpuA);
      end
    end
    idleA();
    expDispA = 8'h20;
    checkOutput("A busy cycles",     busyCycles,      2048);
    checkOutput("A clear_done",      busA.clear_done, 1'b1);
    checkOutput("A done while busy", doneWhileBusy,   0);
    tick();
    checkOutput("A clear_done pulse", busA.clear_done, 1'b0);
    for (int i = 0; i < DEPTHA; i++) modelA[i] = 8'h20;

    applyStimulus(1'b1, 1'b1, 1'b1, 11'h000, 11'h000, 8'h00);
    checkOutput("A disp 0x000 blank", busA.disp_rdata, 8'h20);
    applyStimulus(1'b1, 1'b1, 1'b1, 11'h000, 11'h7FF, 8'h00);
    checkOutput("A disp 0x7FF blank", busA.disp_rdata, 8'h20);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h123, 11'h000, 8'h00);
    checkOutput("A mid-clear write dropped", busA.cpu_rdata, 8'h20);

    // ---- Randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      weN    = 1'($urandom_range(0, 1));
      reN    = 1'($urandom_range(0, 1));
      dispRe = 1'($urandom_range(0, 1));
      cAddr  = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 31));
      dAddr  = ($urandom_range(0, 1) == 0) ? cAddr : 11'($urandom_range(0, 31));
      wData  = 8'($urandom);
      applyStimulus(weN, reN, dispRe, cAddr, dAddr, wData);
    end

    // ---- Reset part-way through a clear ----
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h050, 11'h000, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h100, 11'h000, 8'hA5);
    busA.clear_req = 1'b1;
    tick();
    busA.clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checkOutput("A busy before abort", busA.busy, 1'b1);
    reset_n = 1'b0;
    tick();
    checkOutput("A busy after abort",    busA.busy,       1'b0);
    checkOutput("A done after abort",    busA.clear_done, 1'b0);
    checkOutput("A rdata after abort",   busA.cpu_rdata,  8'h00);
    reset_n = 1'b1;
    expCpuA  = 8'h00;
    expDispA = 8'h00;
    for (int i = 0; i < 100; i++) modelA[i] = 8'h20;
    modelA[100] = 'x;
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h050, 11'h000, 8'h00);
    checkOutput("A 0x050 cleared", busA.cpu_rdata, 8'h20);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h100, 11'h000, 8'h00);
    checkOutput("A 0x100 kept", busA.cpu_rdata, 8'hA5);

    // ---- 1000-word instance: out-of-range handling and clear length ----
    driveB(1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 8'h12);
    driveB(1'b0, 1'b1, 1'b0, 10'h3E7, 10'h000, 8'h9C);
    driveB(1'b0, 1'b1, 1'b0, 10'h3E8, 10'h000, 8'h33);
    driveB(1'b1, 1'b0, 1'b1, 10'h000, 10'h3E7, 8'h00);
    checkOutput("B read 0x000",      busB.cpu_rdata,   8'h12);
    checkOutput("B disp 0x3E7",      busB.disp_rdata,  8'h9C);
    driveB(1'b1, 1'b0, 1'b1, 10'h3E8, 10'h3E8, 8'h00);
    checkOutput("B oor cpu data",    busB.cpu_rdata,   8'h00);
    checkOutput("B oor cpu rvalid",  busB.cpu_rvalid,  1'b1);
    checkOutput("B oor disp data",   busB.disp_rdata,  8'h00);
    checkOutput("B oor disp rvalid", busB.disp_rvalid, 1'b1);
    driveB(1'b1, 1'b0, 1'b1, 10'h3E7, 10'h3E7, 8'h00);
    driveB(1'b0, 1'b1, 1'b1, 10'h3E9, 10'h3E9, 8'h5A);
    checkOutput("B oor collision",   busB.disp_rdata,  8'h00);
    checkOutput("B write no rvalid", busB.cpu_rvalid,  1'b0);
    driveB(1'b1, 1'b0, 1'b0, 10'h3E7, 10'h000, 8'h00);
    checkOutput("B last word intact", busB.cpu_rdata,  8'h9C);

    busB.clear_req = 1'b1;
    tick();
    busB.clear_req = 1'b0;
    busyCycles = 0;
    while (busB.busy === 1'b1 && busyCycles < 3000) begin
      busyCycles++;
      tick();
    end
    checkOutput("B busy cycles", busyCycles,      1000);
    checkOutput("B clear_done",  busB.clear_done, 1'b1);
    driveB(1'b1, 1'b0, 1'b1, 10'h3E7, 10'h000, 8'h00);
    checkOutput("B 0x3E7 blank", busB.cpu_rdata,  8'h20);
    checkOutput("B 0x000 blank", busB.disp_rdata, 8'h20);
    checkOutput("B done pulse",  busB.clear_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
